// File: rtl/ysyx_25060166_imem_rsp_if.sv
// Fetch request/response bundle between the IFU and the instruction memory.
// Request side: valid/ready with byte address; response side: valid/ready with data and fault flag.
// The master drives request and response-accept; the slave drives ready, response data and fault.
interface ysyx_25060166_imem_rsp_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_addr;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_err;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/ysyx_25060166_imem_rsp.sv
// Instruction memory with a preload port; one outstanding fetch, fault on misaligned/out-of-range pc.
// Latency: response valid LATENCY+1 cycles after the acceptance edge.
// Backpressure: response held stable until resp_ready; no new request accepted until back in IDLE.
module ysyx_25060166_imem_rsp #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] MEMBASE = 'h8000_0000,
   parameter int               DEPTH   = 1024,
   parameter int               LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   ysyx_25060166_imem_rsp_if.slave bus,
   input  logic                   ld_en,
   input  logic [WIDTH-1:0]       ld_addr,
   input  logic [WIDTH-1:0]       ld_data
);

   localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Size of the window in bytes, one bit wider so the top of the window cannot wrap.
   localparam logic [WIDTH:0]   MEM_BYTES = (WIDTH+1)'(DEPTH) << 2;
   localparam logic [3:0]       CNT_LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [WIDTH-1:0] addr_q;
   logic             enter_resp;
   logic             req_ready, resp_valid;
   logic [WIDTH-1:0] resp_data;
   logic             resp_err;
   logic [WIDTH-1:0] lk_addr;
   logic             rd_ok;
   logic [WIDTH-1:0] rd_word;

   logic [WIDTH-1:0] mem [DEPTH];

   // Aligned and inside [MEMBASE, MEMBASE+DEPTH*4); the subtraction only happens when a >= MEMBASE.
   function automatic logic in_range(input logic [WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && (a >= MEMBASE) && ({1'b0, a - MEMBASE} < MEM_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [WIDTH-1:0] a);
      return IDX_W'((a - MEMBASE) >> 2);
   endfunction

   // With zero wait states the lookup happens on the acceptance edge, so use the live address.
   assign lk_addr = (state == IDLE) ? bus.req_addr : addr_q;
   assign rd_ok   = in_range(lk_addr);
   assign rd_word = mem[word_idx(lk_addr)];

   // Next-state, wait counter and handshake outputs.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               if (LATENCY == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counter, latched address and the registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         addr_q    <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && bus.req_valid) addr_q <= bus.req_addr;
         // Memory is read before this edge's preload write lands, so a same-edge load is not seen.
         if (enter_resp) begin
            resp_data <= rd_ok ? rd_word : '0;
            resp_err  <= ~rd_ok;
         end
      end
   end

   // Preload port; not reset so contents survive a reset, bad addresses are dropped.
   always_ff @(posedge clk) begin
      if (ld_en && in_range(ld_addr)) mem[word_idx(ld_addr)] <= ld_data;
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_data  = resp_data;
   assign bus.resp_err   = resp_err;

endmodule
